// File: rtl/noc_pkg.sv
// ============================================================================
// Module   : noc_pkg
// Brief    : Shared flit format for the NoC local network interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int FLIT_W = 16;

    typedef struct packed {
        logic [7:0] payload;
        logic [3:0] dx;
        logic [3:0] dy;
    } flit_t;

endpackage

`default_nettype wire

// File: rtl/ni_fifo.sv
// ============================================================================
// Module   : ni_fifo
// Brief    : Synchronous FIFO with wrap-bit pointers; a pop frees a full slot
//            for a push in the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ni_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/noc_local_ni.sv
// ============================================================================
// Module   : noc_local_ni
// Brief    : PE <-> router local-port interface with credit-based injection
//            and credit-returning ejection buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module noc_local_ni
    import noc_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CREDITS  = 4,
    parameter int XCOORD   = 0,
    parameter int YCOORD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        tx_data_i,
    input  logic [7:0]        tx_dest_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [FLIT_W-1:0] data_o,
    output logic              valid_o,
    input  logic              credit_i,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              valid_i,
    output logic              credit_o,
    output logic [7:0]        rx_data_o,
    output logic [7:0]        rx_src_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              err_o
);

    localparam int CW = $clog2(CREDITS + 1);

    if (XCOORD > 15 || YCOORD > 15 || TX_DEPTH < 2 ||
        (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_param_check
        $error("noc_local_ni: illegal parameter set");
    end

    logic              r_run;
    logic [CW-1:0]     r_credit_cnt;
    logic              r_valid;
    logic [FLIT_W-1:0] r_data;
    logic              r_credit_o;
    logic              r_err;

    flit_t             w_tx_flit;
    flit_t             w_rx_head;
    logic [FLIT_W-1:0] w_tx_dout;
    logic [FLIT_W-1:0] w_rx_dout;
    logic [FLIT_W-1:0] w_issue_flit;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_push;
    logic              w_issue;
    logic              w_rx_pop;
    logic              w_rx_drop;
    logic              w_credit_ovf;

    assign w_tx_flit  = '{payload: tx_data_i, dx: tx_dest_i[7:4], dy: tx_dest_i[3:0]};
    // r_run keeps tx_ready_o low until the first clock after reset release
    assign tx_ready_o = r_run && !w_tx_full;
    assign w_tx_push  = tx_valid_i && tx_ready_o;
    // An empty queue lets an accepted flit bypass straight into the issue register
    assign w_issue      = (r_credit_cnt != '0) && (!w_tx_empty || w_tx_push);
    assign w_issue_flit = w_tx_empty ? FLIT_W'(w_tx_flit) : w_tx_dout;
    assign w_credit_ovf = credit_i && !w_issue && (r_credit_cnt == CW'(CREDITS));

    ni_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (FLIT_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_push && !(w_tx_empty && w_issue)),
        .pop   (w_issue && !w_tx_empty),
        .din   (FLIT_W'(w_tx_flit)),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    assign w_rx_pop   = !w_rx_empty && rx_ready_i;
    assign w_rx_drop  = valid_i && w_rx_full && !w_rx_pop;
    assign w_rx_head  = flit_t'(w_rx_dout);
    assign rx_valid_o = !w_rx_empty;
    assign rx_data_o  = rx_valid_o ? w_rx_head.payload : '0;
    assign rx_src_o   = rx_valid_o ? {w_rx_head.dx, w_rx_head.dy} : '0;

    ni_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (FLIT_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_i),
        .pop   (w_rx_pop),
        .din   (data_i),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run        <= 1'b0;
            r_credit_cnt <= CW'(CREDITS);
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_credit_o   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_valid    <= w_issue;
            r_credit_o <= w_rx_pop;
            if (w_issue) r_data <= w_issue_flit;
            if (w_issue && !credit_i)
                r_credit_cnt <= r_credit_cnt - CW'(1);
            else if (!w_issue && credit_i && !w_credit_ovf)
                r_credit_cnt <= r_credit_cnt + CW'(1);
            if (w_credit_ovf || w_rx_drop) r_err <= 1'b1;
        end
    end

    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign credit_o = r_credit_o;
    assign err_o    = r_err;

endmodule

`default_nettype wire
